// File: rtl/simon64_96_key_expander_pkg.sv
// Shared constants, state encoding and helpers for the SIMON64/96 key expander.
// Optional build macro: RK_PARITY_EN (per-entry even-parity storage and check).
package simon64_96_key_expander_pkg;

    localparam int WORD   = 32;   // round-key / half-block width n
    localparam int KWORDS = 3;    // master-key words m
    localparam int ROUNDS = 42;   // round count T = register-file depth
    localparam int IDX_W  = 6;    // width of idx / zPtr / rdAddr

    localparam logic [IDX_W-1:0] FIRST_GEN_IDX = 6'd3;   // first generated entry (== KWORDS)
    localparam logic [IDX_W-1:0] LAST_IDX      = 6'd41;  // last entry (ROUNDS-1)

    // SIMON z2 sequence; bit 0 is the first element used (leftmost in the usual notation).
    localparam logic [61:0] Z2 = 62'b11_0011011010_0111111000_1000010100_0110010010_1100000011_1011110101;

    // Round constant c = 2^n - 4; folds the NOT of k[i-m] and the constant 3 together.
    localparam logic [WORD-1:0] C_CONST = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    // Even-parity bit: makes the total count of ones across word and bit even.
    function automatic logic even_parity(input logic [WORD-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/simon64_96_key_expander_if.sv
// Handshake and read-port bundle between the key expander and the cipher stage.
// Optional build macro: RK_PARITY_EN adds the rkParityErr signal.
interface simon64_96_key_expander_if;
    import simon64_96_key_expander_pkg::*;

    logic                 start;
    logic [95:0]          key;
    logic                 busy;
    logic                 keysValid;
    logic                 done;
    logic [IDX_W-1:0]     rdAddr;
    logic [WORD-1:0]      rdData;
`ifdef RK_PARITY_EN
    logic                 rkParityErr;
`endif

    // Key-expander side.
    modport slave (
`ifdef RK_PARITY_EN
        output rkParityErr,
`endif
        input  start,
        input  key,
        input  rdAddr,
        output busy,
        output keysValid,
        output done,
        output rdData
    );

    // Consumer (cipher / controller) side.
    modport master (
`ifdef RK_PARITY_EN
        input  rkParityErr,
`endif
        output start,
        output key,
        output rdAddr,
        input  busy,
        input  keysValid,
        input  done,
        input  rdData
    );

endinterface

// File: rtl/simon64_96_key_expander_ks_round.sv
// One SIMON64/96 key-schedule step (m = 3), purely combinational:
//   t = ROR3(kPrev1); t ^= ROR1(t); kNext = kPrev3 ^ t ^ z ^ 0xFFFF_FFFC
module simon_ks_round
    import simon64_96_key_expander_pkg::*;
(
    input  logic [WORD-1:0] kPrev3,
    input  logic [WORD-1:0] kPrev1,
    input  logic            zBit,
    output logic [WORD-1:0] kNext
);

    logic [WORD-1:0] w_ror3;
    logic [WORD-1:0] w_t;

    assign w_ror3 = {kPrev1[2:0], kPrev1[WORD-1:3]};
    assign w_t    = w_ror3 ^ {w_ror3[0], w_ror3[WORD-1:1]};
    assign kNext  = kPrev3 ^ w_t ^ {{(WORD-1){1'b0}}, zBit} ^ C_CONST;

endmodule

// File: rtl/simon64_96_key_expander.sv
// Iterative SIMON64/96 key schedule: loads the 3 master-key words, then
// generates one round key per clock into a 42-entry register file that the
// cipher stage reads by index. Optional build macro: RK_PARITY_EN.
module simon64_96_key_expander
    import simon64_96_key_expander_pkg::*;
(
    input  logic clk,
    input  logic rst,
    simon64_96_key_expander_if.slave ks_if
);

    state_e           r_state;
    state_e           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_zptr;
    logic             r_busy;
    logic             r_keys_valid;
    logic             r_done;
    logic [WORD-1:0]  r_rk [ROUNDS];
`ifdef RK_PARITY_EN
    logic             r_par [ROUNDS];
    logic             w_parity_err;
`endif

    logic             w_accept;
    logic             w_expand;
    logic             w_last;
    logic             w_addr_ok;
    logic [WORD-1:0]  w_k_prev3;
    logic [WORD-1:0]  w_k_prev1;
    logic [WORD-1:0]  w_k_next;
    logic [WORD-1:0]  w_rd_data;

    assign w_accept  = (r_state == ST_IDLE) && ks_if.start;
    assign w_expand  = (r_state == ST_EXPAND);
    assign w_last    = w_expand && (r_idx == LAST_IDX);
    assign w_addr_ok = (ks_if.rdAddr <= LAST_IDX);

    // idx stays within 3..42, so both taps always land inside the file.
    assign w_k_prev3 = r_rk[r_idx - 6'd3];
    assign w_k_prev1 = r_rk[r_idx - 6'd1];

    simon_ks_round u_round (
        .kPrev3 (w_k_prev3),
        .kPrev1 (w_k_prev1),
        .zBit   (Z2[r_zptr]),
        .kNext  (w_k_next)
    );

    // Next-state logic: leave IDLE on start, return after the last entry is written.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ks_if.start) begin
                    w_state_next = ST_EXPAND;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                if (r_idx == LAST_IDX) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_EXPAND;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, counters and status flags; start is ignored while expanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= FIRST_GEN_IDX;
            r_zptr       <= 6'd0;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_idx        <= FIRST_GEN_IDX;
                r_zptr       <= 6'd0;
                r_busy       <= 1'b1;
                r_keys_valid <= 1'b0;
                r_done       <= 1'b0;
            end else if (w_expand) begin
                r_idx        <= r_idx + 6'd1;
                r_zptr       <= r_zptr + 6'd1;
                r_busy       <= ~w_last;
                r_keys_valid <= w_last;
                r_done       <= w_last;
            end else begin
                r_done       <= 1'b0;
            end
        end
    end

    // Round-key storage; contents are meaningless until keysValid, so no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rk[0] <= ks_if.key[31:0];
            r_rk[1] <= ks_if.key[63:32];
            r_rk[2] <= ks_if.key[95:64];
        end else if (w_expand) begin
            r_rk[r_idx] <= w_k_next;
        end
    end

`ifdef RK_PARITY_EN
    // Parity bits written alongside each round key.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_par[0] <= even_parity(ks_if.key[31:0]);
            r_par[1] <= even_parity(ks_if.key[63:32]);
            r_par[2] <= even_parity(ks_if.key[95:64]);
        end else if (w_expand) begin
            r_par[r_idx] <= even_parity(w_k_next);
        end
    end

    // Parity check on the addressed entry, only meaningful once keys are valid.
    always_comb begin
        w_parity_err = 1'b0;
        if (r_keys_valid && w_addr_ok) begin
            w_parity_err = (even_parity(r_rk[ks_if.rdAddr]) != r_par[ks_if.rdAddr]);
        end else begin
            w_parity_err = 1'b0;
        end
    end

    assign ks_if.rkParityErr = w_parity_err;
`endif

    // Combinational read port; out-of-range indices read as zero.
    always_comb begin
        w_rd_data = {WORD{1'b0}};
        if (w_addr_ok) begin
            w_rd_data = r_rk[ks_if.rdAddr];
        end else begin
            w_rd_data = {WORD{1'b0}};
        end
    end

    assign ks_if.rdData    = w_rd_data;
    assign ks_if.busy      = r_busy;
    assign ks_if.keysValid = r_keys_valid;
    assign ks_if.done      = r_done;

endmodule

// File: tb/tb_simon64_96_key_expander.sv
// Directed testbench for simon64_96_key_expander: reset state, handshake timing,
// hand-computed round keys, published SIMON64/96 cipher vector, back-to-back
// starts, mid-expansion reset and out-of-range reads.
module tb_simon64_96_key_expander;

    localparam logic [95:0] KEY_ZERO = 96'h0;
    localparam logic [95:0] KEY_REF  = 96'h131211100b0a090803020100;
    localparam logic [63:0] PT_REF   = 64'h6f7220676e696c63;
    localparam logic [63:0] CT_REF   = 64'h5ca2e27f111a8fc8;

    logic        clk;
    logic        rst;
    int          n_vec;
    int          n_mis;
    int          cnt;
    logic [31:0] tb_rk [42];
    logic [63:0] ct;
    logic [63:0] pt;

    simon64_96_key_expander_if ks_if ();

    simon64_96_key_expander dut (
        .clk   (clk),
        .rst   (rst),
        .ks_if (ks_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_all();
        for (int i = 0; i < 42; i++) begin
            ks_if.rdAddr = i[5:0];
            #1;
            tb_rk[i] = ks_if.rdData;
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] sf(input logic [31:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] p);
        logic [31:0] x, y, t;
        x = p[63:32];
        y = p[31:0];
        for (int i = 0; i < 42; i++) begin
            t = x;
            x = y ^ sf(x) ^ tb_rk[i];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [63:0] decrypt(input logic [63:0] c);
        logic [31:0] x, y, t;
        x = c[63:32];
        y = c[31:0];
        for (int i = 41; i >= 0; i--) begin
            t = y;
            y = x ^ sf(y) ^ tb_rk[i];
            x = t;
        end
        return {x, y};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec        = 0;
        n_mis        = 0;
        rst          = 1'b1;
        ks_if.start  = 1'b0;
        ks_if.key    = KEY_ZERO;
        ks_if.rdAddr = 6'd0;

        // Reset state
        #12;
        check("reset_flags", {61'd0, ks_if.busy, ks_if.done, ks_if.keysValid}, 64'd0);
        rst = 1'b0;

        // Run 1: all-zero key, start held high well into the expansion,
        // key input changed after acceptance (must not be re-sampled).
        ks_if.start = 1'b1;
        tick();                                   // E0
        check("e0_flags", {61'd0, ks_if.busy, ks_if.done, ks_if.keysValid}, 64'b100);
        ks_if.key = KEY_REF;
        for (int e = 1; e <= 38; e++) begin
            tick();
            check("busy_window", {61'd0, ks_if.busy, ks_if.done, ks_if.keysValid}, 64'b100);
            if (e == 30) ks_if.start = 1'b0;
        end
        tick();                                   // E39
        check("e39_flags", {61'd0, ks_if.busy, ks_if.done, ks_if.keysValid}, 64'b011);

        // Hand-computed expansion of the zero key
        ks_if.rdAddr = 6'd0; #1; check("k0_rk0", {32'd0, ks_if.rdData}, 64'h0);
        ks_if.rdAddr = 6'd2; #1; check("k0_rk2", {32'd0, ks_if.rdData}, 64'h0);
        ks_if.rdAddr = 6'd3; #1; check("k0_rk3", {32'd0, ks_if.rdData}, 64'hFFFF_FFFD);
        ks_if.rdAddr = 6'd4; #1; check("k0_rk4", {32'd0, ks_if.rdData}, 64'h9FFF_FFFC);

        // Run 2: back-to-back start on the edge right after done
        ks_if.start = 1'b1;
        ks_if.key   = KEY_REF;
        tick();                                   // E40 = new accept edge
        check("b2b_accept", {61'd0, ks_if.busy, ks_if.done, ks_if.keysValid}, 64'b100);
        ks_if.start = 1'b0;
        cnt = 0;
        while (cnt < 60 && ks_if.done !== 1'b1) begin
            tick();
            cnt++;
        end
        check("done_latency", 64'(cnt), 64'd39);
        check("b2b_valid", {63'd0, ks_if.keysValid}, 64'd1);
        tick();
        check("done_pulse_end", {61'd0, ks_if.busy, ks_if.done, ks_if.keysValid}, 64'b001);

        read_all();
        check("ref_rk0", {32'd0, tb_rk[0]}, 64'h0302_0100);
        check("ref_rk1", {32'd0, tb_rk[1]}, 64'h0b0a_0908);
        check("ref_rk2", {32'd0, tb_rk[2]}, 64'h1312_1110);
        check("ref_rk3", {32'd0, tb_rk[3]}, 64'hffae_9dce);
        ct = encrypt(PT_REF);
        check("encrypt_ref", ct, CT_REF);
        pt = decrypt(CT_REF);
        check("decrypt_ref", pt, PT_REF);

        // Out-of-range read addresses return zero
        for (int a = 42; a < 64; a++) begin
            ks_if.rdAddr = a[5:0];
            #1;
            check("rd_out_of_range", {32'd0, ks_if.rdData}, 64'h0);
        end

        // Reset in the middle of an expansion
        ks_if.start = 1'b1;
        ks_if.key   = KEY_ZERO;
        tick();
        ks_if.start = 1'b0;
        repeat (19) tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_flags", {61'd0, ks_if.busy, ks_if.done, ks_if.keysValid}, 64'd0);
        #2;
        rst = 1'b0;

        // Fresh expansion after the reset completes with normal latency
        ks_if.start = 1'b1;
        ks_if.key   = KEY_REF;
        tick();
        ks_if.start = 1'b0;
        cnt = 0;
        while (cnt < 60 && ks_if.keysValid !== 1'b1) begin
            tick();
            cnt++;
        end
        check("postrst_latency", 64'(cnt), 64'd39);
        check("postrst_done", {63'd0, ks_if.done}, 64'd1);
        read_all();
        ct = encrypt(PT_REF);
        check("postrst_encrypt", ct, CT_REF);

`ifdef RK_PARITY_EN
        ks_if.rdAddr = 6'd5;
        #1;
        check("parity_clean", {63'd0, ks_if.rkParityErr}, 64'd0);
        force dut.r_rk[5] = tb_rk[5] ^ 32'h0000_0001;
        #1;
        check("parity_flip_hit", {63'd0, ks_if.rkParityErr}, 64'd1);
        ks_if.rdAddr = 6'd6;
        #1;
        check("parity_flip_other", {63'd0, ks_if.rkParityErr}, 64'd0);
        release dut.r_rk[5];
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
